hps_fifo_reader: RTL and testbench

FPGA-side drain engine for the HPS-to-FPGA on-chip FIFO. The HPS writes words into the FIFO; this block polls the FIFO's CSR fill level and pulls words through the FIFO's Avalon-MM read ("out") slave. It then hands the words to FPGA logic on a valid/ready stream. It sits in the top level beside `soc_system`, wired to the `fifo_hps_to_fpga_out_*` ports.

---
 rtl/hps_fifo_pkg.sv | 15 +
 rtl/hps_fifo_outbuf.sv | 73 +++++++
 rtl/hps_fifo_reader.sv | 143 ++++++++++++++
 tb/tb_hps_fifo_reader.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hps_fifo_pkg.sv
// Shared types and CSR map for the HPS-to-FPGA FIFO drain engine.
package hps_fifo_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPoll,
        StPollWait,
        StDrain,
        StGap
    } state_e;

    localparam logic [2:0] FILL_LEVEL = 3'd0;
    localparam logic [2:0] I_STATUS   = 3'd1;

endpackage

// File: rtl/hps_fifo_outbuf.sv
// Shift-register output FIFO; entry 0 is the stream head so src_* come straight from flops.
module hps_fifo_outbuf
    import hps_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    output logic              full_o,
    output logic              empty_o,
    output logic              full_next_o,
    output logic [DATA_W-1:0] src_data_o,
    output logic              src_valid_o,
    input  logic              src_ready_i
);

    localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

    logic [DATA_W-1:0] data_q [BUF_DEPTH];
    logic [DATA_W-1:0] data_d [BUF_DEPTH];
    logic              vld_q  [BUF_DEPTH];
    logic              vld_d  [BUF_DEPTH];
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CntW-1:0]   wr_idx;
    logic              pop;

    assign pop    = vld_q[0] & src_ready_i;
    // With a simultaneous pop the entries shift down first, so the new word lands one lower.
    assign wr_idx = pop ? cnt_q - CntW'(1) : cnt_q;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (pop) begin
            for (int i = 0; i < int'(BUF_DEPTH) - 1; i++) begin
                data_d[i] = data_q[i+1];
                vld_d[i]  = vld_q[i+1];
            end
            vld_d[BUF_DEPTH-1] = 1'b0;
        end
        if (push_i) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                if (CntW'(i) == wr_idx) begin
                    data_d[i] = push_data_i;
                    vld_d[i]  = 1'b1;
                end
            end
        end
        cnt_d = cnt_q + CntW'(push_i) - CntW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= '{default: '0};
            vld_q  <= '{default: 1'b0};
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
        end
    end

    assign full_o      = (cnt_q == CntW'(BUF_DEPTH));
    assign empty_o     = (cnt_q == '0);
    assign full_next_o = (cnt_d == CntW'(BUF_DEPTH));
    assign src_data_o  = data_q[0];
    assign src_valid_o = vld_q[0];

endmodule

// File: rtl/hps_fifo_reader.sv
// Polls the HPS-to-FPGA FIFO fill level over CSR and drains words through the Avalon-MM
// out slave into a small register buffer feeding a valid/ready stream.
module hps_fifo_reader
    import hps_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned POLL_GAP  = 8,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [2:0]        csr_address,
    output logic              csr_read,
    output logic              csr_write,
    output logic [31:0]       csr_writedata,
    input  logic [31:0]       csr_readdata,
    output logic              fifo_read,
    input  logic [DATA_W-1:0] fifo_readdata,
    input  logic              fifo_waitrequest,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic [31:0]       words_read,
    output logic              busy
);

    localparam int unsigned RemW      = $clog2(MAX_BURST + 1);
    localparam int unsigned GapW      = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [31:0] MaxBurstW = 32'(MAX_BURST);

    state_e          state_q, state_d;
    logic [RemW-1:0] remaining_q, remaining_d, rem_next;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    logic [31:0]     words_read_q, words_read_d;
    logic            csr_read_q, csr_read_d;
    logic            fifo_read_q, fifo_read_d;
    logic            busy_q, busy_d;
    logic            accept, held;
    logic            buf_full, buf_empty, buf_full_next;

    assign accept   = fifo_read_q & ~fifo_waitrequest;
    assign held     = fifo_read_q & fifo_waitrequest;
    assign rem_next = accept ? remaining_q - RemW'(1) : remaining_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = rem_next;
        gap_cnt_d   = gap_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StPoll;
            end
            StPoll: begin
                state_d = StPollWait;
            end
            StPollWait: begin
                if (csr_readdata == '0) begin
                    gap_cnt_d = GapW'(POLL_GAP - 1);
                    state_d   = StGap;
                end else begin
                    remaining_d = (csr_readdata > MaxBurstW) ? RemW'(MAX_BURST)
                                                             : csr_readdata[RemW-1:0];
                    state_d     = StDrain;
                end
            end
            StDrain: begin
                // A stalled beat is never abandoned; leave only once nothing is outstanding.
                if (!held) begin
                    if (rem_next == '0) begin
                        state_d = enable ? StPoll : StIdle;
                    end else if (!enable) begin
                        state_d = StIdle;
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == '0) begin
                    state_d = enable ? StPoll : StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q - GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        csr_read_d   = (state_d == StPoll);
        fifo_read_d  = held | ((state_d == StDrain) & enable & ~buf_full_next);
        busy_d       = (state_d != StIdle);
        words_read_d = words_read_q + 32'(accept);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            remaining_q  <= '0;
            gap_cnt_q    <= '0;
            words_read_q <= '0;
            csr_read_q   <= 1'b0;
            fifo_read_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            gap_cnt_q    <= gap_cnt_d;
            words_read_q <= words_read_d;
            csr_read_q   <= csr_read_d;
            fifo_read_q  <= fifo_read_d;
            busy_q       <= busy_d;
        end
    end

    hps_fifo_outbuf #(
        .DATA_W   (DATA_W),
        .BUF_DEPTH(BUF_DEPTH)
    ) u_outbuf (
        .clk_i      (clk),
        .reset_i    (reset),
        .push_i     (accept),
        .push_data_i(fifo_readdata),
        .full_o     (buf_full),
        .empty_o    (buf_empty),
        .full_next_o(buf_full_next),
        .src_data_o (src_data),
        .src_valid_o(src_valid),
        .src_ready_i(src_ready)
    );

    no_push_when_full_a: assert property (@(posedge clk) disable iff (reset)
        accept |-> (!buf_full || (src_valid && src_ready)));
    valid_matches_fill_a: assert property (@(posedge clk) disable iff (reset)
        src_valid == !buf_empty);

    assign csr_address   = FILL_LEVEL;
    assign csr_write     = 1'b0;
    assign csr_writedata = '0;
    assign csr_read      = csr_read_q;
    assign fifo_read     = fifo_read_q;
    assign words_read    = words_read_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_hps_fifo_reader.sv
// Bench: emulates the HPS FIFO as a word queue and scoreboards the stream, counters and handshakes.
module tb_hps_fifo_reader;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MAX_BURST = 16;
    localparam int unsigned POLL_GAP  = 8;
    localparam int unsigned BUF_DEPTH = 2;

    logic              clk = 1'b0;
    logic              reset, enable;
    logic [2:0]        csr_address;
    logic              csr_read, csr_write;
    logic [31:0]       csr_writedata, csr_readdata;
    logic              fifo_read, fifo_waitrequest;
    logic [DATA_W-1:0] fifo_readdata, src_data;
    logic              src_valid, src_ready, busy;
    logic [31:0]       words_read;

    always #5 clk = ~clk;

    hps_fifo_reader #(
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST),
        .POLL_GAP (POLL_GAP),
        .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .csr_address     (csr_address),
        .csr_read        (csr_read),
        .csr_write       (csr_write),
        .csr_writedata   (csr_writedata),
        .csr_readdata    (csr_readdata),
        .fifo_read       (fifo_read),
        .fifo_readdata   (fifo_readdata),
        .fifo_waitrequest(fifo_waitrequest),
        .src_data        (src_data),
        .src_valid       (src_valid),
        .src_ready       (src_ready),
        .words_read      (words_read),
        .busy            (busy)
    );

    int unsigned       n_cmp = 0, n_err = 0, cyc = 0;
    logic [DATA_W-1:0] hps_q[$], exp_q[$], got_q[$];
    int unsigned       poll_cyc[$], acc_cyc[$], bursts[$];
    logic [31:0]       model_words = '0;
    int unsigned       budget = 0, burst_n = 0, pushed_total = 0, delivered_total = 0;
    bit                csr_pend = 0, override_arm = 0, active = 0, rst_seen = 0;
    bit                prev_held = 0, prev_csr = 0;
    logic [31:0]       csr_snap = '0, fill_override = '0;
    int unsigned       want_ready_pct = 100, want_wait_pct = 0;
    bit                want_enable = 0, want_reset = 1;
    bit                stall_arm = 0;
    int unsigned       stall_beat = 0, stall_len = 0, stall_left = 0, stall_hi = 0;
    int unsigned       en_cyc;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_words(input int unsigned n, input logic [DATA_W-1:0] base);
        for (int i = 0; i < int'(n); i++) hps_q.push_back(base + DATA_W'(i));
        pushed_total += n;
    endtask

    // Checks outputs for the current cycle, then advances the model past the coming edge.
    task automatic observe();
        bit acc, pop;
        if (active) begin
            chk("csr_tieoff", {csr_address, csr_write, csr_writedata}, '0);
            chk("words_read", words_read, model_words);
            chk("src_valid", src_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) chk("src_data", src_data, exp_q[0]);
            if (prev_held) chk("fifo_read_hold", fifo_read, 1);
            else if (fifo_read) chk("read_needs_free_entry", exp_q.size() < BUF_DEPTH, 1);
            if (csr_read || fifo_read) chk("busy_when_active", busy, 1);
            if (csr_read) chk("csr_read_single_pulse", prev_csr, 0);
            if (rst_seen) begin
                chk("reset_ctrl", {csr_read, fifo_read, src_valid, busy, csr_address}, '0);
                chk("reset_words_read", words_read, '0);
                chk("reset_src_data", src_data, '0);
            end
        end
        acc = fifo_read && !fifo_waitrequest;
        pop = src_valid && src_ready;
        if (reset) begin
            if (acc && hps_q.size() != 0) void'(hps_q.pop_front());
            exp_q.delete();
            model_words = '0;
            budget      = 0;
            burst_n     = 0;
            csr_pend    = 0;
            prev_held   = 0;
            prev_csr    = 0;
            rst_seen    = 1;
            active      = 1;
        end else begin
            rst_seen = 0;
            if (pop && exp_q.size() != 0) begin
                got_q.push_back(exp_q.pop_front());
                delivered_total++;
            end
            if (acc) begin
                chk("read_within_fill", (budget != 0) && (hps_q.size() != 0), 1);
                if (budget != 0) budget--;
                if (hps_q.size() != 0) exp_q.push_back(hps_q.pop_front());
                model_words++;
                burst_n++;
                acc_cyc.push_back(cyc);
            end
            if (csr_read) begin
                csr_pend = 1;
                csr_snap = hps_q.size();
                poll_cyc.push_back(cyc);
                bursts.push_back(burst_n);
                burst_n = 0;
            end
            prev_held = fifo_read && fifo_waitrequest;
            prev_csr  = csr_read;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        reset     = want_reset;
        enable    = want_enable;
        src_ready = ($urandom_range(99) < want_ready_pct);
        fifo_readdata = (hps_q.size() != 0) ? hps_q[0] : DATA_W'($urandom);
        if (csr_pend) begin
            csr_readdata = override_arm ? fill_override : csr_snap;
            override_arm = 0;
            csr_pend     = 0;
            budget       = (csr_readdata > 32'(MAX_BURST)) ? MAX_BURST : int'(csr_readdata);
        end else begin
            csr_readdata = $urandom;
        end
        if (stall_arm && fifo_read && model_words == 32'(stall_beat)) begin
            stall_left = stall_len;
            stall_arm  = 0;
        end
        if (stall_left != 0 && fifo_read) begin
            fifo_waitrequest = 1'b1;
            stall_left--;
            stall_hi++;
        end else begin
            fifo_waitrequest = ($urandom_range(99) < want_wait_pct);
        end
        #1;
        observe();
    endtask

    task automatic run(input int unsigned n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        want_reset  = 1;
        want_enable = 0;
        stall_left  = 0;
        stall_arm   = 0;
        run(2);
        want_reset = 0;
        hps_q.delete();
        got_q.delete();
        poll_cyc.delete();
        acc_cyc.delete();
        bursts.delete();
        pushed_total    = 0;
        delivered_total = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; enable = 0; src_ready = 1; fifo_waitrequest = 0;
        csr_readdata = '0; fifo_readdata = '0;

        // Reset values, then a short 3-word burst at full rate.
        do_reset();
        step();
        push_words(3, 32'hA000_0000);
        want_enable = 1;
        en_cyc = cyc + 1;
        run(12);
        chk("t1_poll_count", poll_cyc.size() >= 2, 1);
        chk("t1_accept_count", acc_cyc.size(), 3);
        if (poll_cyc.size() >= 2 && acc_cyc.size() >= 3) begin
            chk("t1_enable_to_poll", poll_cyc[0] - en_cyc, 1);
            chk("t1_poll_to_read", acc_cyc[0] - poll_cyc[0], 2);
            chk("t1_consecutive", acc_cyc[2] - acc_cyc[0], 2);
            chk("t1_repoll", poll_cyc[1] - acc_cyc[2], 1);
        end
        chk("t1_words_read", words_read, 3);
        chk("t1_delivered", got_q.size(), 3);
        for (int i = 0; i < 3 && i < int'(got_q.size()); i++)
            chk("t1_data", got_q[i], 32'hA000_0000 + 32'(i));

        // 40 words split into bursts of 16, 16, 8.
        do_reset();
        push_words(40, 32'hB000_0000);
        want_enable = 1;
        for (int i = 0; i < 200 && words_read != 40; i++) step();
        run(15);
        chk("t2_words_read", words_read, 40);
        chk("t2_delivered", delivered_total, 40);
        chk("t2_poll_count", bursts.size() >= 5, 1);
        if (bursts.size() >= 5) begin
            chk("t2_burst1", bursts[1], 16);
            chk("t2_burst2", bursts[2], 16);
            chk("t2_burst3", bursts[3], 8);
            chk("t2_burst4", bursts[4], 0);
        end
        if (acc_cyc.size() >= 17) chk("t2_inter_burst_gap", acc_cyc[16] - acc_cyc[15], 3);

        // Huge fill value must saturate to MAX_BURST.
        do_reset();
        push_words(20, 32'hB100_0000);
        override_arm  = 1;
        fill_override = 32'h8000_0002;
        want_enable   = 1;
        run(40);
        chk("t2s_poll_count", bursts.size() >= 2, 1);
        if (bursts.size() >= 2) chk("t2s_saturated_burst", bursts[1], 16);
        chk("t2s_words_read", words_read, 20);

        // Empty FIFO: periodic polls, never a read.
        do_reset();
        want_enable = 1;
        run(45);
        chk("t3_poll_count", poll_cyc.size() >= 4, 1);
        for (int i = 0; i + 1 < int'(poll_cyc.size()) && i < 3; i++)
            chk("t3_poll_period", poll_cyc[i+1] - poll_cyc[i], 2 + POLL_GAP);
        chk("t3_no_reads", acc_cyc.size(), 0);

        // Five-cycle stall on beat 2.
        do_reset();
        push_words(4, 32'hC000_0000);
        stall_arm = 1; stall_beat = 2; stall_len = 5; stall_hi = 0;
        want_enable = 1;
        run(25);
        chk("t4_stall_cycles", stall_hi, 5);
        chk("t4_words_read", words_read, 4);
        chk("t4_delivered", delivered_total, 4);
        for (int i = 0; i < 4 && i < int'(got_q.size()); i++)
            chk("t4_data", got_q[i], 32'hC000_0000 + 32'(i));

        // Back-pressure: only the buffer fills, then everything drains in order.
        do_reset();
        want_ready_pct = 0;
        push_words(5, 32'hD000_0000);
        want_enable = 1;
        run(20);
        chk("t5_words_blocked", words_read, 2);
        chk("t5_read_idle", fifo_read, 0);
        want_ready_pct = 100;
        run(30);
        chk("t5_words_read", words_read, 5);
        chk("t5_delivered", got_q.size(), 5);
        for (int i = 0; i < 5 && i < int'(got_q.size()); i++)
            chk("t5_data", got_q[i], 32'hD000_0000 + 32'(i));

        // Enable drops during a stall, then reset lands mid-drain.
        do_reset();
        push_words(10, 32'hE000_0000);
        stall_arm = 1; stall_beat = 1; stall_len = 6; stall_hi = 0;
        want_enable = 1;
        for (int i = 0; i < 30 && stall_hi == 0; i++) step();
        chk("t6_stall_started", stall_hi != 0, 1);
        want_enable = 0;
        for (int i = 0; i < 30 && busy !== 1'b0; i++) step();
        chk("t6_went_idle", busy, 0);
        chk("t6_stall_completed", stall_hi, 6);
        chk("t6_words_read", words_read, 2);
        run(5);
        chk("t6_no_more_reads", acc_cyc.size(), 2);
        chk("t6_hps_remaining", hps_q.size(), 8);
        stall_arm = 1; stall_beat = 4; stall_len = 20; stall_hi = 0;
        want_enable = 1;
        for (int i = 0; i < 40 && stall_hi < 2; i++) step();
        chk("t6_second_stall", stall_hi >= 2, 1);
        want_reset = 1;
        step();
        want_reset  = 0;
        want_enable = 0;
        stall_left  = 0;
        step();
        chk("t6_reset_fifo_read", fifo_read, 0);
        run(5);
        chk("t6_idle_after_reset", busy, 0);

        // Randomised traffic with stalls, back-pressure and enable toggles.
        do_reset();
        want_wait_pct  = 25;
        want_ready_pct = 70;
        want_enable    = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 30 && hps_q.size() < 50)
                push_words($urandom_range(3, 1), DATA_W'($urandom));
            if ($urandom_range(99) < 2) want_enable = !want_enable;
            step();
        end
        want_enable    = 1;
        want_wait_pct  = 0;
        want_ready_pct = 100;
        for (int i = 0; i < 400 && (hps_q.size() != 0 || exp_q.size() != 0); i++) step();
        run(3);
        chk("t7_drained", hps_q.size() + exp_q.size(), 0);
        chk("t7_delivered", delivered_total, pushed_total);
        chk("t7_words_read", words_read, 32'(pushed_total));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
